// File: rtl/msrv32_irq_controller.sv
// External interrupt controller: NUM_SRC synchronised sources with level/edge gateways,
// per-source enable and priority, a global threshold and a claim/complete register.
module msrv32_irq_controller #(
  parameter int NUM_SRC     = 8,
  parameter int PRIO_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               ms_riscv32_mp_clk_in,
  input  logic               ms_riscv32_mp_rst_in,
  input  logic [NUM_SRC-1:0] src_irq_in,
  input  logic               reg_wr_en_in,
  input  logic               reg_rd_en_in,
  input  logic [7:0]         reg_addr_in,
  input  logic [31:0]        reg_wdata_in,
  output logic [31:0]        reg_rdata_out,
  output logic               reg_ready_out,
  output logic               eirq_out,
  output logic [4:0]         claim_id_out
);
  localparam int ID_W = 5;

  logic [NUM_SRC-1:0] sync_reg [SYNC_STAGES+1];
  logic [NUM_SRC:1]   s_id, s_prev_id;
  logic [NUM_SRC:1]   pending_reg, pending_next, enable_reg, enable_next;
  logic [NUM_SRC:1]   edge_reg, edge_next, inflight_reg, inflight_next;
  logic [NUM_SRC:1]   claim_clr, complete_clr, set_vec;
  logic [PRIO_W-1:0]  prio_reg  [1:NUM_SRC];
  logic [PRIO_W-1:0]  prio_next [1:NUM_SRC];
  logic [PRIO_W-1:0]  threshold_reg, threshold_next, best_prio;
  logic [ID_W-1:0]    claim_id_reg, claim_id_next;
  logic [31:0]        rdata_reg, rdata_next;
  logic               ready_reg, claim_fire, complete_wr;
  logic               unused_bits;

  assign s_id        = sync_reg[SYNC_STAGES-1];
  assign s_prev_id   = sync_reg[SYNC_STAGES];
  assign claim_fire  = reg_rd_en_in && (reg_addr_in == 8'h90) && (claim_id_reg != '0);
  assign complete_wr = reg_wr_en_in && (reg_addr_in == 8'h90);
  assign unused_bits = ^reg_wdata_in;

  function automatic logic [31:0] to_word(input logic [NUM_SRC:1] v);
    to_word = '0;
    to_word[NUM_SRC:1] = v;
  endfunction

  genvar gi;
  generate
    for (gi = 1; gi <= NUM_SRC; gi++) begin : g_src
      assign claim_clr[gi]    = claim_fire && (claim_id_reg == ID_W'(gi));
      assign complete_clr[gi] = complete_wr && (reg_wdata_in[4:0] == ID_W'(gi));
      assign prio_next[gi]    = (reg_wr_en_in && reg_addr_in == 8'(4 * gi)) ?
                                reg_wdata_in[PRIO_W-1:0] : prio_reg[gi];
      // Edge mode lets a new edge beat a same-cycle claim; level mode lets the claim win.
      assign set_vec[gi]      = edge_reg[gi] ? (s_id[gi] & ~s_prev_id[gi])
                                             : (s_id[gi] & ~inflight_reg[gi]);
      assign pending_next[gi] = edge_reg[gi] ? ((pending_reg[gi] & ~claim_clr[gi]) | set_vec[gi])
                                             : ((pending_reg[gi] | set_vec[gi]) & ~claim_clr[gi]);
    end
  endgenerate

  always_comb begin
    enable_next    = enable_reg;
    edge_next      = edge_reg;
    threshold_next = threshold_reg;
    if (reg_wr_en_in && reg_addr_in == 8'h84) enable_next    = reg_wdata_in[NUM_SRC:1];
    if (reg_wr_en_in && reg_addr_in == 8'h88) edge_next      = reg_wdata_in[NUM_SRC:1];
    if (reg_wr_en_in && reg_addr_in == 8'h8C) threshold_next = reg_wdata_in[PRIO_W-1:0];
    inflight_next = (inflight_reg & ~complete_clr) | claim_clr;
  end

  // Arbitrate on next-state values so claim_id_out matches post-edge registers.
  always_comb begin
    claim_id_next = '0;
    best_prio     = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (pending_next[i] && enable_next[i] && (prio_next[i] > threshold_next) &&
          (claim_id_next == '0 || prio_next[i] > best_prio)) begin
        claim_id_next = ID_W'(i);
        best_prio     = prio_next[i];
      end
    end
  end

  always_comb begin
    rdata_next = '0;
    for (int i = 1; i <= NUM_SRC; i++)
      if (reg_addr_in == 8'(4 * i)) rdata_next = 32'(prio_reg[i]);
    case (reg_addr_in)
      8'h80:   rdata_next = to_word(pending_reg);
      8'h84:   rdata_next = to_word(enable_reg);
      8'h88:   rdata_next = to_word(edge_reg);
      8'h8C:   rdata_next = 32'(threshold_reg);
      8'h90:   rdata_next = 32'(claim_id_reg);
      default: ;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      for (int k = 0; k <= SYNC_STAGES; k++) sync_reg[k] <= '0;
      for (int i = 1; i <= NUM_SRC; i++) prio_reg[i] <= '0;
      pending_reg   <= '0;
      enable_reg    <= '0;
      edge_reg      <= '0;
      inflight_reg  <= '0;
      threshold_reg <= '0;
      claim_id_reg  <= '0;
      rdata_reg     <= '0;
      ready_reg     <= 1'b0;
    end else begin
      sync_reg[0] <= src_irq_in;
      for (int k = 1; k <= SYNC_STAGES; k++) sync_reg[k] <= sync_reg[k-1];
      for (int i = 1; i <= NUM_SRC; i++) prio_reg[i] <= prio_next[i];
      pending_reg   <= pending_next;
      enable_reg    <= enable_next;
      edge_reg      <= edge_next;
      inflight_reg  <= inflight_next;
      threshold_reg <= threshold_next;
      claim_id_reg  <= claim_id_next;
      if (reg_rd_en_in) rdata_reg <= rdata_next;
      ready_reg     <= reg_rd_en_in | reg_wr_en_in;
    end
  end

  assign reg_rdata_out = rdata_reg;
  assign reg_ready_out = ready_reg;
  assign claim_id_out  = claim_id_reg;
  assign eirq_out      = (claim_id_reg != '0);
endmodule

// File: doc/msrv32_irq_controller.md
Name: msrv32_irq_controller

Overview:
- Parametrised external-interrupt controller that generalises the core's single external interrupt line to NUM_SRC prioritised sources.
- Per source it provides synchronisation, level/edge gateway, pending, enable and priority, plus a global threshold and a claim/complete register.
- Sits between SoC interrupt sources and the core; eirq_out drives ms_riscv32_mp_eirq_in.

Parameters:
NUM_SRC, 8, number of sources (1..31); source IDs 1..NUM_SRC, ID 0 = "none"
PRIO_W, 3, priority/threshold width (1..8)
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
ms_riscv32_mp_clk_in  in  1  clock
ms_riscv32_mp_rst_in  in  1  reset, asynchronous, active-low
src_irq_in  in  NUM_SRC  raw async sources; bit k = ID k+1
reg_wr_en_in  in  1  register write strobe
reg_rd_en_in  in  1  register read strobe
reg_addr_in  in  8  byte address, word aligned
reg_wdata_in  in  32  write data
reg_rdata_out  out  32  read data, registered
reg_ready_out  out  1  read/write acknowledge pulse
eirq_out  out  1  external interrupt request to core
claim_id_out  out  5  current best ID (debug), 0 if none

Behaviour:
- Reset (async assert, sync release): all pending, enable, edge-mode, in-flight, priority and threshold = 0; sync chain = 0; reg_rdata_out = 0, reg_ready_out = 0, eirq_out = 0, claim_id_out = 0.
- Register map (unlisted/RO-written addresses: write ignored, read 0):
  - 0x04*i: priority of ID i, i = 1..NUM_SRC, RW. Low PRIO_W bits stored; rest read 0. Address 0x00 reads 0.
  - 0x80 pending: RO, bit i = ID i.
  - 0x84 enable: RW.
  - 0x88 edge mode: RW, 1 = rising-edge, 0 = level-high.
  - 0x8C threshold: RW, PRIO_W bits.
  - 0x90 claim (read) / complete (write).
  - Bit 0 and bits above NUM_SRC of all bitmaps are read 0 and not writable.
- Bus:
  - Every access completes in one cycle: reg_ready_out = 1 the cycle after the strobe edge.
  - reg_rdata_out is valid in that same cycle and holds its value until the next read.
  - Read and write in the same cycle: the write takes effect and the read returns the pre-write value.
- Synchroniser: SYNC_STAGES flops per source; s_i = last stage, s_prev_i = one further stage for edge detect.
- Gateway (per ID i):
  - Level mode: pending_i set when s_i = 1 and not in-flight_i. Pending stays set until claimed, even if the source drops.
  - Edge mode: pending_i set on s_i & ~s_prev_i, including while in-flight (one-deep; further edges while pending are merged).
  - Set and claim-clear of the same ID in the same cycle: in edge mode the set wins; in level mode the clear wins.
- Arbitration:
  - Eligible = pending & enable & (priority > threshold).
  - Winner = highest priority; ties go to the lowest ID; 0 if none eligible.
  - Computed from next-state register values and registered as claim_id_out, so it always matches post-edge register contents.
  - eirq_out = (claim_id_out != 0).
- Claim (read of 0x90):
  - Returns claim_id_out as sampled at the strobe edge.
  - If non-zero: at that same edge pending is cleared and in-flight is set for that ID.
  - A claim of 0 has no side effects.
- Complete (write of 0x90): reg_wdata_in[4:0] = ID. Clears in-flight if the ID is valid and in-flight; otherwise ignored.
- Latency: a source asserted before edge E gives pending = 1 and eirq_out = 1 after edge E+SYNC_STAGES (assuming enabled and eligible).
- Changes to enable, priority or threshold take effect on eirq_out at the write edge.
- Reset mid-operation: all state (including in-flight) is lost; sources still asserted re-pend after the sync latency once reset is released.

Test Plan:
- Level source: prio[3]=2, enable=0x08, threshold=0, hold src_irq_in[2]=1 -> eirq_out=1 after SYNC_STAGES+1 edges; claim reads 3; eirq_out=0 at the claim edge; it does not re-assert while held until 0x90 is written with 3, then re-asserts after 1 edge.
- Priority and tie: IDs 2, 5, 6 pending with prio 4, 6, 6 -> claims return 5, then 6, then 2, then 0; the claim of 0 changes no state.
- Threshold: prio[1]=3, threshold=3 -> eirq_out=0; write threshold=2 -> eirq_out=1 at the write edge.
- Edge mode: edge[4]=1, two pulses before claim -> one claim returns 4, next claim returns 0. A pulse after claim but before complete -> pending[4]=1 and the next claim returns 4.
- Bus rules: read 0x84 and write 0x84=0x1E in the same cycle -> rdata = old value and ready = 1. A write to 0x80 is ignored. Read 0xA0 returns 0. Priority write 0xFF (PRIO_W=3) reads back 0x7.
- Async reset asserted mid-claim with ID 3 in flight -> all outputs 0 immediately. After release with the source still high -> eirq_out=0, because the enable register was cleared by reset. After re-enabling -> the interrupt re-pends.
